// File: rtl/fifo_packer.sv
// Packs RATIO narrow words popped from a zero-latency FIFO into one wide word
// on a registered valid/ready output; a drain request flushes out a partial word.
module fifo_packer #(
  parameter int WIDTH     = 16,
  parameter int RATIO     = 4,
  parameter bit LSB_FIRST = 1'b1,
  localparam int CW       = $clog2(RATIO) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   up_valid,
  input  logic [WIDTH-1:0]       up_data,
  output logic                   up_pop,
  input  logic                   drain,
  output logic                   dn_valid,
  input  logic                   dn_ready,
  output logic [WIDTH*RATIO-1:0] dn_data,
  output logic [CW-1:0]          dn_cnt,
  output logic [2:0]             state_dbg
);

  localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;

  // Handshakes: upstream word consumed when up_valid && up_pop (up_pop is
  // combinational); downstream word transferred when dn_valid && dn_ready.

  logic [RATIO-1:0][WIDTH-1:0] stage_q, stage_nxt;
  logic [CW-1:0]               lane_cnt, fill;
  logic [IW-1:0]               lane_idx;
  logic                        drain_pend;
  logic                        out_free, last_lane, cap, complete, drain_eff, emit;

  always_comb begin
    out_free  = !dn_valid || dn_ready;
    last_lane = (lane_cnt == CW'(RATIO - 1));
    // A completing capture needs the output register to be free this cycle.
    up_pop    = rst_n && up_valid && !flush && !(last_lane && !out_free);
    cap       = up_valid && up_pop;
    complete  = cap && last_lane;
    drain_eff = drain || drain_pend;
    fill      = lane_cnt + CW'(cap);
    emit      = complete || (drain_eff && (fill != '0) && out_free);
    lane_idx  = LSB_FIRST ? lane_cnt[IW-1:0] : IW'(RATIO - 1) - lane_cnt[IW-1:0];
    stage_nxt = stage_q;
    if (cap) stage_nxt[lane_idx] = up_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid   <= 1'b0;
      dn_data    <= '0;
      dn_cnt     <= '0;
      stage_q    <= '0;
      lane_cnt   <= '0;
      drain_pend <= 1'b0;
    end else if (flush) begin
      dn_valid   <= 1'b0;
      dn_data    <= '0;
      dn_cnt     <= '0;
      stage_q    <= '0;
      lane_cnt   <= '0;
      drain_pend <= 1'b0;
    end else if (emit) begin
      dn_valid   <= 1'b1;
      dn_data    <= stage_nxt;
      dn_cnt     <= fill;
      stage_q    <= '0;
      lane_cnt   <= '0;
      drain_pend <= 1'b0;
    end else begin
      if (dn_valid && dn_ready) dn_valid <= 1'b0;
      stage_q  <= stage_nxt;
      lane_cnt <= fill;
      // An empty drain is dropped; a blocked one waits for the output.
      if (drain_eff && (fill == '0)) drain_pend <= 1'b0;
      else if (drain)                drain_pend <= 1'b1;
    end
  end

  // {hold, fill, idle}; fill and hold may be set together.
  assign state_dbg = {dn_valid && !dn_ready, lane_cnt != '0, (lane_cnt == '0) && !dn_valid};

endmodule

// File: tb/tb_fifo_packer.sv
// Directed bench for fifo_packer: driver tasks push expected packed words into
// a queue, and a monitor pops and compares on every output transfer.
module tb_fifo_packer;
  localparam int WIDTH = 16;
  localparam int RATIO = 4;
  localparam int CW    = $clog2(RATIO) + 1;
  localparam int DW    = WIDTH * RATIO;
  localparam int W     = CW + DW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             up_valid;
  logic [WIDTH-1:0] up_data;
  logic             up_pop;
  logic             drain;
  logic             dn_valid;
  logic             dn_ready;
  logic [DW-1:0]    dn_data;
  logic [CW-1:0]    dn_cnt;
  logic [2:0]       state_dbg;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  fifo_packer #(.WIDTH(WIDTH), .RATIO(RATIO), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .up_valid(up_valid), .up_data(up_data), .up_pop(up_pop),
    .drain(drain), .dn_valid(dn_valid), .dn_ready(dn_ready),
    .dn_data(dn_data), .dn_cnt(dn_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [CW-1:0] cnt, input logic [DW-1:0] d);
    exp_q.push_back({cnt, d});
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic send(input logic [WIDTH-1:0] d, input logic exp_pop, input string name);
    up_valid = 1'b1;
    up_data  = d;
    @(negedge clk);
    chk(name, W'(up_pop), W'(exp_pop));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    up_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send4(input logic [WIDTH-1:0] b, input string name);
    for (int i = 0; i < 4; i++) send(b + WIDTH'(i), 1'b1, name);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && dn_valid && dn_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {dn_cnt, dn_data}, '0);
      end else begin
        chk("dn_word", {dn_cnt, dn_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; up_valid = 1'b0; up_data = '0;
    drain = 1'b0; dn_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dn_valid", W'(dn_valid), '0);
    chk("rst_dn_data", W'(dn_data), '0);
    chk("rst_dn_cnt", W'(dn_cnt), '0);
    chk("rst_up_pop", W'(up_pop), '0);
    chk("rst_state", W'(state_dbg), W'(3'b001));
    rst_n = 1'b1;
    dn_ready = 1'b1;
    @(posedge clk); #1;

    // 1: basic pack, one-cycle latency
    push_exp(3'd4, 64'h4444_3333_2222_1111);
    send(16'h1111, 1'b1, "t1_pop");
    send(16'h2222, 1'b1, "t1_pop");
    send(16'h3333, 1'b1, "t1_pop");
    send(16'h4444, 1'b1, "t1_pop");
    chk("t1_latency", W'(dn_valid), W'(1));
    idle(2);

    // 2: back-to-back eight words, no bubbles
    push_exp(3'd4, 64'h0013_0012_0011_0010);
    push_exp(3'd4, 64'h0017_0016_0015_0014);
    for (int i = 0; i < 8; i++) send(16'h0010 + 16'(i), 1'b1, "t2_pop");
    idle(2);

    // 3: backpressure blocks the completing pop only
    dn_ready = 1'b0;
    push_exp(3'd4, 64'hA003_A002_A001_A000);
    push_exp(3'd4, 64'hB003_B002_B001_B000);
    send4(16'hA000, "t3_popA");
    send(16'hB000, 1'b1, "t3_popB");
    send(16'hB001, 1'b1, "t3_popB");
    send(16'hB002, 1'b1, "t3_popB");
    up_valid = 1'b1; up_data = 16'hB003;
    @(negedge clk);
    chk("t3_blocked_pop", W'(up_pop), '0);
    chk("t3_hold_data", W'(dn_data), W'(64'hA003_A002_A001_A000));
    @(posedge clk); #1;
    dn_ready = 1'b1;
    send(16'hB003, 1'b1, "t3_unblock_pop");
    idle(2);

    // 4: partial drain, then empty drain emits nothing
    push_exp(3'd2, 64'h0000_0000_BBBB_AAAA);
    send(16'hAAAA, 1'b1, "t4_pop");
    send(16'hBBBB, 1'b1, "t4_pop");
    up_valid = 1'b0; drain = 1'b1;
    @(posedge clk); #1;
    drain = 1'b0;
    chk("t4_drain_cnt", W'(dn_cnt), W'(2));
    idle(2);
    drain = 1'b1;
    @(posedge clk); #1;
    drain = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_empty_drain", W'(dn_valid), '0);
    end
    @(posedge clk); #1;

    // 5a: drain waits for a blocked output
    dn_ready = 1'b0;
    push_exp(3'd4, 64'hC003_C002_C001_C000);
    push_exp(3'd1, 64'h0000_0000_0000_D000);
    send4(16'hC000, "t5_popC");
    send(16'hD000, 1'b1, "t5_popD");
    up_valid = 1'b0; drain = 1'b1;
    @(posedge clk); #1;
    drain = 1'b0;
    idle(2);
    chk("t5_hold", {dn_cnt, dn_data}, {3'd4, 64'hC003_C002_C001_C000});
    dn_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_drain_out", {dn_valid, dn_cnt}, W'({1'b1, 3'd1}));
    idle(2);

    // 5b: drain on the completing pop gives exactly one word
    push_exp(3'd4, 64'hE003_E002_E001_E000);
    send(16'hE000, 1'b1, "t5b_pop");
    send(16'hE001, 1'b1, "t5b_pop");
    send(16'hE002, 1'b1, "t5b_pop");
    drain = 1'b1;
    send(16'hE003, 1'b1, "t5b_pop");
    drain = 1'b0;
    idle(4);
    chk("t5b_no_extra", W'(dn_valid), '0);

    // 6a: flush mid-fill
    send(16'hF000, 1'b1, "t6_popF");
    send(16'hF001, 1'b1, "t6_popF");
    up_valid = 1'b1; up_data = 16'hF002; flush = 1'b1;
    @(negedge clk);
    chk("t6_flush_pop", W'(up_pop), '0);
    @(posedge clk); #1;
    flush = 1'b0; up_valid = 1'b0;
    chk("t6_flush_state", W'(state_dbg), W'(3'b001));
    push_exp(3'd4, 64'h6003_6002_6001_6000);
    send4(16'h6000, "t6_popG");
    idle(2);

    // 6b: flush discards a held output word
    dn_ready = 1'b0;
    send4(16'h7000, "t6_popH");
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t6_flush_out", {dn_valid, dn_cnt, dn_data}, '0);
    dn_ready = 1'b1;
    push_exp(3'd4, 64'h8003_8002_8001_8000);
    send4(16'h8000, "t6_popI");
    idle(2);

    // 6c: async reset mid-stream
    send(16'h9000, 1'b1, "t6_popJ");
    send(16'h9001, 1'b1, "t6_popJ");
    rst_n = 1'b0; up_valid = 1'b1; up_data = 16'h9002;
    #2;
    chk("t6_rst_pop", W'(up_pop), '0);
    chk("t6_rst_out", {dn_valid, dn_cnt, dn_data}, '0);
    chk("t6_rst_state", W'(state_dbg), W'(3'b001));
    @(posedge clk); #1;
    rst_n = 1'b1; up_valid = 1'b0;
    @(posedge clk); #1;
    push_exp(3'd4, 64'h5003_5002_5001_5000);
    send4(16'h5000, "t6_popK");
    idle(4);

    chk("exp_q_empty", W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
